// File: rtl/mmio_pkg.sv
// Shared register-window offsets and STATUS bit positions for the MMIO store responder.
package mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CYCLE  = 4'h8;
    localparam logic [3:0] OFF_DONE   = 4'hC;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens on the same edge.
module mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_cnt == FULL_CNT);
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    // Head is forced to zero when empty so stale storage never shows after reset.
    assign dout      = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_store_responder.sv
// MMIO responder: TX byte FIFO, STATUS, completion code, and an optional cycle
// counter built only when MMIO_CYCLE_CNT_EN is defined.
module mmio_store_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic [31:0] exit_code
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    w_off;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_done_set;
    logic [31:0]   w_status;
    logic [31:0]   w_cycle;
    logic          w_unused_bits;
    logic          r_ovf;
    logic          r_done;
    logic [31:0]   r_exit;

    // Byte lanes are ignored: only word accesses exist in this window.
    assign w_off         = {DataAdr[3:2], 2'b00};
    assign w_unused_bits = ^DataAdr[1:0];
    assign sel           = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign w_wr          = MemWrite && sel;
    assign w_push        = w_wr && (w_off == OFF_TXDATA);
    assign w_pop         = tx_valid && tx_ready;
    assign w_done_set    = w_wr && (w_off == OFF_DONE) && !r_done;

    mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_push),
        .din   (WriteData[7:0]),
        .pop   (w_pop),
        .dout  (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign tx_valid  = !w_empty;
    assign done      = r_done;
    assign exit_code = r_exit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_exit <= '0;
        end else begin
            if (w_wr && (w_off == OFF_STATUS))  r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_done_set) begin
                r_done <= 1'b1;
                r_exit <= WriteData;
            end
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    // Stops on the edge that records completion so the final value is the run length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     r_cycle <= '0;
        else if (!r_done && !w_done_set) r_cycle <= r_cycle + 1'b1;
    end
    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_CNT_LSB +: 4]     = 4'(w_count);
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (w_off)
                OFF_STATUS: ReadData = w_status;
                OFF_CYCLE:  ReadData = w_cycle;
                OFF_DONE:   ReadData = r_exit;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule
